// File: rtl/mul_div_unit_pkg.sv
// Shared types for the iterative MIPS multiply/divide unit.
package mul_div_unit_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } md_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } md_state_t;

   function automatic word_t abs_w(input word_t v);
      return v[31] ? -v : v;
   endfunction

endpackage

// File: rtl/mul_div_unit_div_radix2_step.sv
// One restoring radix-2 division iteration; quotient bits shift in behind the dividend.
module mul_div_unit_div_radix2_step
   import mul_div_unit_pkg::*;
(
   input  word_t rem_i,
   input  word_t dvd_i,
   input  word_t dvs_i,
   output word_t rem_o,
   output word_t quo_o
);

   logic [32:0] shifted;
   logic [33:0] diff;
   logic        unused_hi;

   assign shifted   = {rem_i, dvd_i[31]};
   assign diff      = {1'b0, shifted} - {2'b00, dvs_i};
   // both high bits are provably zero whenever they would be kept
   assign unused_hi = diff[32] ^ shifted[32];

   always_comb begin
      rem_o = shifted[31:0];
      quo_o = {dvd_i[30:0], 1'b0};
      if (!diff[33]) begin
         rem_o = diff[31:0];
         quo_o = {dvd_i[30:0], 1'b1};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit driving the HI/LO write port.
module mul_div_unit
   import mul_div_unit_pkg::*;
(
   input  logic   clk,
   input  logic   resetn,
   input  logic   start,
   input  md_op_t op,
   input  word_t  a,
   input  word_t  b,
   input  logic   flush,
   output logic   busy,
   output logic   hi_write,
   output logic   lo_write,
   output word_t  hi_data,
   output word_t  lo_data
);

   md_state_t   state_q, state_d;
   logic        sa_q, sa_d, sb_q, sb_d;
   word_t       dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
   logic [4:0]  cnt_q, cnt_d;
   word_t       res_hi_q, res_hi_d, res_lo_q, res_lo_d;

   word_t       step_rem, step_quo;
   logic [63:0] prod;
   logic        is_signed;

   mul_div_unit_div_radix2_step u_div_radix2_step (
      .rem_i (rem_q),
      .dvd_i (dvd_q),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .quo_o (step_quo)
   );

   assign prod = 64'({1'b0, dvd_q} * {1'b0, dvs_q});

   always_comb begin
      state_d   = state_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      res_hi_d  = res_hi_q;
      res_lo_d  = res_lo_q;
      is_signed = (op == OP_MULT) || (op == OP_DIV);
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               // sign bits stay clear for unsigned ops, so later sign fixes are no-ops
               sa_d    = is_signed & a[31];
               sb_d    = is_signed & b[31];
               dvd_d   = is_signed ? abs_w(a) : a;
               dvs_d   = is_signed ? abs_w(b) : b;
               rem_d   = '0;
               cnt_d   = '0;
               state_d = ((op == OP_MULT) || (op == OP_MULTU)) ? S_MUL : S_DIV;
            end
         end
         S_MUL: begin
            {res_hi_d, res_lo_d} = (sa_q ^ sb_q) ? -prod : prod;
            state_d              = S_DONE;
         end
         S_DIV: begin
            rem_d = step_rem;
            dvd_d = step_quo;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               // on divide-by-zero the remainder is |a|, so the same fix restores raw a
               res_hi_d = sa_q ? -step_rem : step_rem;
               if (dvs_q == '0)
                  res_lo_d = '1;
               else
                  res_lo_d = (sa_q ^ sb_q) ? -step_quo : step_quo;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d  = S_IDLE;
         res_hi_d = res_hi_q;
         res_lo_d = res_lo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign hi_write = (state_q == S_DONE);
   assign lo_write = (state_q == S_DONE);
   assign hi_data  = res_hi_q;
   assign lo_data  = res_lo_q;

endmodule
